snowbro2_cen_ctrl: RTL

//  Runtime-programmable fractional clock-enable scheduler on the 94.5 MHz domain.

---
 rtl/snowbro2_cen_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/snowbro2_cen_ctrl.sv
// Fractional N/M clock-enable scheduler on CLK96 with power-of-two sub-enables, handshaked
// ratio reconfiguration and pause/ack. Define CEN_CATCHUP_EN to repay ticks missed while paused.
module snowbro2_cen_ctrl #(
    parameter int W     = 8,
    parameter int DEF_N = 8,
    parameter int DEF_M = 189
) (
    input  logic         CLK96,
    input  logic         RESET,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_n,
    input  logic [W-1:0] cfg_m,
    output logic         cfg_ready,
    output logic         cfg_err,
    input  logic         pause_req,
    output logic         pause_ack,
    output logic         cen,
    output logic         cenb,
    output logic [2:0]   cen_div,
    output logic [3:0]   debt
);

`ifdef CEN_CATCHUP_EN
    localparam bit CATCHUP = 1'b1;
`else
    localparam bit CATCHUP = 1'b0;
`endif

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    state_t       state;
    logic [W:0]   acc;
    logic [W-1:0] n, m;
    logic [W-1:0] pend_n, pend_m;
    logic [2:0]   cnt;

    logic [W:0] sum, m_ext, m_half;
    logic       fire, paused, half_cross, extra, emit, apply, accept, legal;

    // acc < m and n <= m, so the W+1-bit sum never overflows.
    assign sum        = acc + {1'b0, n};
    assign m_ext      = {1'b0, m};
    assign m_half     = m_ext >> 1;
    assign fire       = (sum >= m_ext);
    assign paused     = (state == PAUSED);
    assign half_cross = (acc < m_half) && (sum >= m_half) && !fire;
    assign extra      = CATCHUP && (state == RUN) && (debt != 4'd0) && !fire && !cen;
    assign emit       = (fire && !paused) || extra;
    // A pending ratio waits for a natural cen boundary, or lands at once while stopped.
    assign apply      = !cfg_ready && (fire || paused);
    assign accept     = cfg_valid && cfg_ready;
    assign legal      = (cfg_n != '0) && (cfg_n <= cfg_m);

    // NOTE: every register here is updated with <= so all next-state terms read the
    // pre-edge values; a blocking = would let later statements see half-updated state.
    always_ff @(posedge CLK96) begin
        if (RESET) begin
            state     <= RUN;
            acc       <= '0;
            n         <= W'(DEF_N);
            m         <= W'(DEF_M);
            pend_n    <= '0;
            pend_m    <= '0;
            cnt       <= '0;
            debt      <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            pause_ack <= 1'b0;
            cen       <= 1'b0;
            cenb      <= 1'b0;
            cen_div   <= '0;
        end else begin
            cen     <= emit;
            cenb    <= half_cross && !paused && !extra;
            cen_div <= emit ? {&cnt, &cnt[1:0], cnt[0]} : 3'b000;
            if (emit)
                cnt <= cnt + 3'd1;

            cfg_err <= accept && !legal;

            if (apply) begin
                n         <= pend_n;
                m         <= pend_m;
                acc       <= '0;
                cfg_ready <= 1'b1;
            end else if (!paused || CATCHUP) begin
                acc <= fire ? sum - m_ext : sum;
            end

            if (accept && legal) begin
                pend_n    <= cfg_n;
                pend_m    <= cfg_m;
                cfg_ready <= 1'b0;
            end

            if (apply)
                debt <= '0;
            else if (extra)
                debt <= debt - 4'd1;
            else if (CATCHUP && paused && fire && debt != 4'hF)
                debt <= debt + 4'd1;

            pause_ack <= paused && pause_req;

            case (state)
                RUN:     if (pause_req) state <= DRAIN;
                DRAIN: begin
                    if (!pause_req)
                        state <= RUN;
                    else if (fire)
                        state <= PAUSED;
                end
                PAUSED:  if (!pause_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
